// File: rtl/nv_ram_rwsp_param.sv
// ---------------------------------------------------------------------------
// nv_ram_rwsp_param
// Parametrised single-clock RAM with one write port and one read port.
// The read address is registered (ra_q), and the array output feeds an
// output-enable data register (dout_q) that drives dout. After reset an
// optional sequencer writes INIT_VALUE to every word. A same-cycle write to
// the word being loaded into dout can optionally be forwarded.
//
// Ports:
//   clk            clock, all state changes on posedge
//   rst            synchronous active-high reset
//   ra / re        read address / read address capture enable
//   ore            output register load enable
//   dout           registered read data
//   wa / we / di   write address / write enable / write data
//   pwrbus_ram_pd  power-down bus, no functional effect
//   init_done      high when the sequencer is idle and the RAM is usable
//
// Sequencer states:
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | user reads and writes are serviced
//   ST_INIT | writing INIT_VALUE to M[init_cnt_q]; user ports ignored
// ---------------------------------------------------------------------------
module nv_ram_rwsp_param #(
    parameter int               DEPTH         = 64,
    parameter int               WIDTH         = 14,
    parameter int               AW            = 6,
    parameter bit               INIT_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VALUE    = '0,
    parameter bit               BYPASS_EN     = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    input  logic             ore,
    output logic [WIDTH-1:0] dout,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [WIDTH-1:0] di,
    input  logic [31:0]      pwrbus_ram_pd,
    output logic             init_done
);

    localparam int          MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          DEPTH_I = DEPTH;
    localparam int          LAST_I  = DEPTH - 1;
    localparam logic [AW:0]   DEPTH_C = DEPTH_I[AW:0];
    localparam logic [AW-1:0] LAST_C  = LAST_I[AW-1:0];

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     init_cnt_q;
    logic              init_done_q;
    logic [AW-1:0]     ra_q;
    logic [WIDTH-1:0]  dout_q;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              wa_valid;
    logic              ra_valid;
    logic [WIDTH-1:0]  dout_ram;
    logic              bypass;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              unused_pd;

    assign unused_pd = ^pwrbus_ram_pd;

    assign wa_valid = ({1'b0, wa} < DEPTH_C);
    assign ra_valid = ({1'b0, ra_q} < DEPTH_C);

    // Out-of-range read addresses return zero rather than aliasing.
    assign dout_ram = ra_valid ? mem[ra_q[MEM_AW-1:0]] : '0;

    // wa == ra_q together with wa_valid guarantees the read word is in range.
    assign bypass = BYPASS_EN && we && wa_valid && (wa == ra_q);

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = wa[MEM_AW-1:0];
        mem_wdata = di;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_addr  = init_cnt_q[MEM_AW-1:0];
            mem_wdata = INIT_VALUE;
        end else if (we && wa_valid) begin
            mem_we = 1'b1;
        end
    end

    // The array has no reset; rst only blocks writes so a reset landing
    // mid-sequence never leaves a stray write behind.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT_ON_RESET ? ST_INIT : ST_IDLE;
            init_cnt_q  <= '0;
            init_done_q <= ~INIT_ON_RESET;
            ra_q        <= '0;
            dout_q      <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == LAST_C) begin
                        state_q     <= ST_IDLE;
                        init_done_q <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (re) begin
                        ra_q <= ra;
                    end
                    if (ore) begin
                        dout_q <= bypass ? di : dout_ram;
                    end
                end
            endcase
        end
    end

    assign dout      = dout_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_nv_ram_rwsp_param.sv
// ---------------------------------------------------------------------------
// tb_nv_ram_rwsp_param
// Four instances share one stimulus stream: default parameters, bypass
// disabled, DEPTH=40, and init disabled. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_nv_ram_rwsp_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  ra;
    logic        re;
    logic        ore;
    logic [5:0]  wa;
    logic        we;
    logic [13:0] di;
    logic [31:0] pwrbus_ram_pd;

    logic [13:0] dout_dflt, dout_nobyp, dout_d40, dout_noinit;
    logic        done_dflt, done_nobyp, done_d40, done_noinit;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nv_ram_rwsp_param u_dflt (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout_dflt),
        .wa(wa), .we(we), .di(di), .pwrbus_ram_pd(pwrbus_ram_pd), .init_done(done_dflt)
    );

    nv_ram_rwsp_param #(.BYPASS_EN(1'b0)) u_nobyp (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout_nobyp),
        .wa(wa), .we(we), .di(di), .pwrbus_ram_pd(pwrbus_ram_pd), .init_done(done_nobyp)
    );

    nv_ram_rwsp_param #(.DEPTH(40), .AW(6)) u_d40 (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout_d40),
        .wa(wa), .we(we), .di(di), .pwrbus_ram_pd(pwrbus_ram_pd), .init_done(done_d40)
    );

    nv_ram_rwsp_param #(.INIT_ON_RESET(1'b0)) u_noinit (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout_noinit),
        .wa(wa), .we(we), .di(di), .pwrbus_ram_pd(pwrbus_ram_pd), .init_done(done_noinit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [13:0] d);
        we = 1'b1; wa = a; di = d;
        tick();
        we = 1'b0;
    endtask

    // re on one edge, ore on the next: dout valid after the second edge.
    task automatic rd(input logic [5:0] a);
        re = 1'b1; ra = a;
        tick();
        re = 1'b0; ore = 1'b1;
        tick();
        ore = 1'b0;
    endtask

    // Counts edges until the default instance finishes init; also records
    // the edge on which the DEPTH=40 instance finished.
    task automatic wait_init(input int start, output int cyc, output int d40_rise);
        cyc = start;
        d40_rise = -1;
        while (cyc < 200 && !done_dflt) begin
            tick();
            cyc++;
            if (done_d40 && d40_rise < 0) d40_rise = cyc;
        end
    endtask

    int cyc;
    int d40_rise;

    initial begin
        rst = 1'b1; ra = '0; re = 1'b0; ore = 1'b0;
        wa = '0; we = 1'b0; di = '0; pwrbus_ram_pd = 32'hDEAD_BEEF;
        repeat (3) tick();

        check("rst_dout", {18'b0, dout_dflt}, 32'h0);
        check("rst_done_dflt", {31'b0, done_dflt}, 32'h0);
        check("rst_done_noinit", {31'b0, done_noinit}, 32'h1);

        // Initial sequencing
        rst = 1'b0;
        check("init_c0_done", {31'b0, done_dflt}, 32'h0);
        wait_init(0, cyc, d40_rise);
        check("init_len_64", cyc, 64);
        check("init_len_d40", d40_rise, 40);
        check("noinit_done", {31'b0, done_noinit}, 32'h1);

        rd(6'd0);  check("init_rd0", {18'b0, dout_dflt}, 32'h0);
        rd(6'd17); check("init_rd17", {18'b0, dout_dflt}, 32'h0);
        rd(6'd63); check("init_rd63", {18'b0, dout_dflt}, 32'h0);

        // Basic write / read and output hold
        wr(6'd5, 14'h2A5);
        re = 1'b1; ra = 6'd5;
        tick();
        re = 1'b0; ore = 1'b1;
        check("rd5_not_yet", {18'b0, dout_dflt}, 32'h0);
        tick();
        ore = 1'b0;
        check("rd5", {18'b0, dout_dflt}, 32'h2A5);
        ra = 6'd0; re = 1'b0;
        repeat (3) tick();
        check("rd5_hold", {18'b0, dout_dflt}, 32'h2A5);

        // Collision on the ore edge with ra_q held at 9
        wr(6'd9, 14'h0AAA);
        re = 1'b1; ra = 6'd9;
        tick();
        re = 1'b0;
        we = 1'b1; wa = 6'd9; di = 14'h1234 & 14'h3FFF; ore = 1'b1;
        tick();
        we = 1'b0;
        check("coll_bypass", {18'b0, dout_dflt}, 32'h1234);
        check("coll_nobyp_old", {18'b0, dout_nobyp}, 32'h0AAA);
        tick();
        ore = 1'b0;
        check("coll_nobyp_new", {18'b0, dout_nobyp}, 32'h1234);

        // Collision on the re edge: write lands first, read sees new data
        we = 1'b1; wa = 6'd20; di = 14'h00F0; re = 1'b1; ra = 6'd20;
        tick();
        we = 1'b0; re = 1'b0; ore = 1'b1;
        tick();
        ore = 1'b0;
        check("re_coll", {18'b0, dout_dflt}, 32'h00F0);

        // Non-power-of-2 depth
        wr(6'd45, 14'h0001);
        rd(6'd45);
        check("d40_oob", {18'b0, dout_d40}, 32'h0);
        check("dflt_45", {18'b0, dout_dflt}, 32'h1);
        wr(6'd39, 14'h0155);
        rd(6'd39);
        check("d40_last", {18'b0, dout_d40}, 32'h155);

        // No-init instance round trip
        wr(6'd0, 14'h03C3);
        rd(6'd0);
        check("noinit_rt", {18'b0, dout_noinit}, 32'h3C3);

        // Reset during init restarts the sequence; user write during init dropped
        wr(6'd50, 14'h0111);
        rst = 1'b1;
        tick();
        check("rst2_dout", {18'b0, dout_dflt}, 32'h0);
        rst = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        we = 1'b1; wa = 6'd3; di = 14'h0007; ore = 1'b1;
        tick();
        we = 1'b0;
        wait_init(1, cyc, d40_rise);
        ore = 1'b0;
        check("reinit_len_64", cyc, 64);
        check("reinit_len_d40", d40_rise, 40);
        check("reinit_dout_held", {18'b0, dout_dflt}, 32'h0);
        rd(6'd3);
        check("init_wr_dropped", {18'b0, dout_dflt}, 32'h0);
        check("noinit_wr3", {18'b0, dout_noinit}, 32'h7);
        rd(6'd50);
        check("reinit_rd50", {18'b0, dout_dflt}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nv_ram_rwsp_param.md
Name: nv_ram_rwsp_param

Overview:
Parametrised single-clock dual-port RAM: one write port, one read port, registered read address and an output-enable data register. It is the generalised successor to the fixed-size rwsp macros and is instantiated by buffers and queues that need arbitrary depth and width. New features over the fixed macros:
- hardware zero-initialisation sequencer after reset;
- optional write-to-read bypass on address collision;
- defined behaviour for non-power-of-2 depth.

Parameters:
DEPTH, 64, number of words; any value 2..4096, need not be a power of 2
WIDTH, 14, data width in bits
AW, 6, address width; must satisfy 2^AW >= DEPTH
INIT_ON_RESET, 1, 1 = sequencer writes INIT_VALUE to every word after reset; 0 = no init, contents undefined
INIT_VALUE, 0, WIDTH-bit value written by the sequencer
BYPASS_EN, 1, 1 = forward write data to dout on a same-cycle address collision

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
ra  input  AW  read address
re  input  1  read address enable; ra captured into ra_d when high
ore  input  1  output register enable; dout_r loads when high
dout  output  WIDTH  read data, driven directly from output register
wa  input  AW  write address
we  input  1  write enable
di  input  WIDTH  write data
pwrbus_ram_pd  input  32  power-down bus; accepted and ignored in this model
init_done  output  1  high when the RAM is usable (sequencer idle)

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high, sampled on posedge clk.
- While rst=1:
  - ra_d, dout_r and init_cnt are cleared to 0.
  - init_busy is set to INIT_ON_RESET.
  - dout=0 and init_done=~INIT_ON_RESET.
  - Memory array is not modified by rst itself.
- Init sequencer (INIT_ON_RESET=1):
  - States: IDLE and INIT.
  - INIT is entered on the first cycle after rst deasserts.
  - Each INIT cycle writes M[init_cnt] <= INIT_VALUE, then init_cnt++.
  - At init_cnt==DEPTH-1 the final write occurs and the state goes to IDLE on the next edge.
  - init_done is registered: it rises exactly DEPTH cycles after the first cycle with rst=0.
  - rst asserted during INIT restarts the sequence from address 0.
- During INIT:
  - we, re and ore are ignored.
  - ra_d and dout_r hold (dout stays 0).
  - User writes are dropped, not queued.
- Write: when we=1, IDLE and wa<DEPTH, M[wa] <= di on the edge. Writes with wa>=DEPTH are dropped silently.
- Read pipeline:
  - Edge N: re=1 captures ra_d <= ra.
  - Cycle N+1: internal dout_ram = M[ra_d], or 0 if ra_d>=DEPTH.
  - Edge N+1 with ore=1: dout_r <= dout_ram, visible on dout.
  - Minimum latency ra->dout is 2 edges.
  - re=0 holds ra_d; ore=0 holds dout.
- Collision on the ore edge (we=1, ore=1, wa==ra_d, wa<DEPTH):
  - BYPASS_EN=1: dout_r <= di (new data).
  - BYPASS_EN=0: dout_r <= old M[ra_d].
  - The array is updated with di in both cases.
- Collision on the re edge (we=1, re=1, wa==ra): no special case. The write lands on the same edge, so the next-cycle read returns new data.
- Repeated ore with re=0 re-reads M[ra_d] and reflects intervening writes.
- pwrbus_ram_pd has no functional effect.
- No assertions on contention; all combinations of we/re/ore are legal.

Test Plan:
1. Default params, rst high 3 cycles then low -> init_done=0 for exactly 64 cycles, then 1. Reading addresses 0, 17 and 63 returns 14'h0.
2. Write di=14'h2A5 at wa=5, then re with ra=5, then ore next cycle -> dout=14'h2A5 two edges after re; dout holds while ore=0.
3. ra_d=9 held, single cycle with we=1, wa=9, di=14'h1234 & 14'h3FFF, ore=1 -> BYPASS_EN=1: dout=new data that edge. BYPASS_EN=0: dout=previous word, and the following ore returns new data.
4. rst reasserted at init cycle 20, then released -> init_done rises 64 cycles after release. A user write issued during init to wa=3 with di=14'h7 is absent afterwards (reads 0).
5. DEPTH=40, AW=6: write wa=45 di=1, then read ra=45 -> dout=0. Write/read wa=39 round-trips its value.
6. INIT_ON_RESET=0 -> init_done=1 in the cycle after rst deasserts. A write to wa=0 followed by a read of address 0 returns the written data.
